// File: rtl/instr_issue_window.sv
// Age-ordered collapsing issue window: launches the oldest hazard-free entry each cycle; younger work may pass.
// Accepted entries launch no earlier than the next cycle; a full window refuses input even while launching.
module instr_issue_window #(
  parameter int DEPTH     = 4,
  parameter int NUM_REGS  = 64,
  parameter int PAYLOAD_W = 128,
  parameter int RD_W      = $clog2(NUM_REGS)
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic                         clear_i,
  input  logic [PAYLOAD_W-1:0]         in_payload_i,
  input  logic [RD_W-1:0]              in_rd_i,
  input  logic [NUM_REGS-1:0]          in_reg_req_i,
  input  logic                         in_blocking_i,
  input  logic                         in_mem_op_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [NUM_REGS-1:0]          locks_i,
  output logic [PAYLOAD_W-1:0]         out_payload_o,
  output logic [RD_W-1:0]              out_rd_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [RD_W-1:0]      rd;
    logic [NUM_REGS-1:0]  req;
    logic                 blocking;
    logic                 mem_op;
  } entry_t;

  entry_t              ent_q [DEPTH];
  entry_t              ent_n [DEPTH];
  entry_t              in_ent;
  logic [DEPTH-1:0]    vld_q, vld_n, elig, exp_vld;
  logic [CNT_W-1:0]    count_q, wr_idx;
  logic [NUM_REGS-1:0] own [DEPTH];
  logic [NUM_REGS-1:0] older;
  logic                older_mem, older_blk;
  logic [IDX_W-1:0]    grant;
  logic                launch, accept;

  assign in_ent = '{payload: in_payload_i, rd: in_rd_i, req: in_reg_req_i,
                    blocking: in_blocking_i, mem_op: in_mem_op_i};

  assign in_ready_o = !arst_i && (count_q < CNT_W'(DEPTH));
  assign count_o    = count_q;
  assign accept     = in_valid_i && in_ready_o;
  assign launch     = out_valid_o && out_ready_i;
  assign wr_idx     = count_q - CNT_W'(launch);

  // Each slot is tested against locks plus everything every valid older slot reads or writes.
  always_comb begin
    older     = locks_i;
    older_mem = 1'b0;
    older_blk = 1'b0;
    elig      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      own[k] = ent_q[k].req;
      if (ent_q[k].rd != '0) own[k][ent_q[k].rd] = 1'b1;
      elig[k] = vld_q[k]
             && ((own[k] & older & ~NUM_REGS'(1)) == '0)
             && !(ent_q[k].mem_op && older_mem)
             && !(ent_q[k].blocking && k != 0)
             && !older_blk;
      if (vld_q[k]) begin
        older     = older | own[k];
        older_mem = older_mem | ent_q[k].mem_op;
        older_blk = older_blk | ent_q[k].blocking;
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (elig[k]) grant = IDX_W'(k);
    end
  end

  assign out_valid_o   = |elig;
  assign out_payload_o = ent_q[grant].payload;
  assign out_rd_o      = ent_q[grant].rd;

  // Collapse above the launched slot, then append; the append wins on the vacated slot.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ent_n[k] = ent_q[k];
      vld_n[k] = vld_q[k];
    end
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (launch && IDX_W'(k) >= grant) begin
        ent_n[k] = ent_q[k+1];
        vld_n[k] = vld_q[k+1];
      end
    end
    if (launch) vld_n[DEPTH-1] = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (accept && CNT_W'(k) == wr_idx) begin
        ent_n[k] = in_ent;
        vld_n[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      vld_q   <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_n;
      count_q <= count_q + CNT_W'(accept) - CNT_W'(launch);
    end
  end

  always_ff @(posedge clk_i) begin
    ent_q <= ent_n;
  end

  always_comb begin
    exp_vld = '0;
    for (int k = 0; k < DEPTH; k++) exp_vld[k] = (CNT_W'(k) < count_q);
  end

  always @(posedge clk_i) begin
    if (!arst_i) begin
      assert (vld_q == exp_vld);
      assert (count_q <= CNT_W'(DEPTH));
    end
  end
endmodule

// File: tb/tb_instr_issue_window.sv
// Bench for instr_issue_window: directed scenarios plus randomized traffic against a queue-based window model.
module tb_instr_issue_window;
  localparam int DEPTH = 4;
  localparam int NR    = 64;
  localparam int PW    = 128;
  localparam int RW    = 6;
  localparam int CW    = 3;

  logic          clk_i = 1'b0;
  logic          arst_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [PW-1:0] in_payload_i = '0;
  logic [RW-1:0] in_rd_i = '0;
  logic [NR-1:0] in_reg_req_i = '0;
  logic          in_blocking_i = 1'b0;
  logic          in_mem_op_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [NR-1:0] locks_i = '0;
  logic [PW-1:0] out_payload_o;
  logic [RW-1:0] out_rd_o;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [CW-1:0] count_o;

  instr_issue_window #(.DEPTH(DEPTH), .NUM_REGS(NR), .PAYLOAD_W(PW)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .clear_i(clear_i),
    .in_payload_i(in_payload_i), .in_rd_i(in_rd_i), .in_reg_req_i(in_reg_req_i),
    .in_blocking_i(in_blocking_i), .in_mem_op_i(in_mem_op_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .locks_i(locks_i),
    .out_payload_o(out_payload_o), .out_rd_o(out_rd_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [PW-1:0] payload;
    logic [RW-1:0] rd;
    logic [NR-1:0] req;
    bit            blk;
    bit            mem;
  } ent_t;

  ent_t mq[$];
  int checks = 0;
  int failures = 0;

  function automatic ent_t mk(int tag, int rd, logic [NR-1:0] req, bit blk, bit mem);
    ent_t e;
    e.payload = {$urandom, $urandom, $urandom, 32'(tag)};
    e.rd      = RW'(rd);
    e.req     = req;
    e.blk     = blk;
    e.mem     = mem;
    return e;
  endfunction

  function automatic logic [NR-1:0] bit_of(int r);
    logic [NR-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  function automatic logic [NR-1:0] touches(ent_t e);
    logic [NR-1:0] v;
    v = e.req;
    if (e.rd != 0) v[e.rd] = 1'b1;
    return v;
  endfunction

  // Oldest entry whose register footprint avoids locks and every older entry's footprint,
  // honouring in-order memory ops and serialising instructions. -1 when none.
  function automatic int m_grant(logic [NR-1:0] lk);
    for (int k = 0; k < mq.size(); k++) begin
      logic [NR-1:0] haz;
      bit ok;
      haz = lk;
      ok  = 1'b1;
      for (int j = 0; j < k; j++) begin
        haz = haz | touches(mq[j]);
        if (mq[j].blk) ok = 1'b0;
        if (mq[j].mem && mq[k].mem) ok = 1'b0;
      end
      if (mq[k].blk && k != 0) ok = 1'b0;
      if (((touches(mq[k]) & haz) & ~NR'(1)) != '0) ok = 1'b0;
      if (ok) return k;
    end
    return -1;
  endfunction

  task automatic put(ent_t e, bit v);
    in_payload_i  = e.payload;
    in_rd_i       = e.rd;
    in_reg_req_i  = e.req;
    in_blocking_i = e.blk;
    in_mem_op_i   = e.mem;
    in_valid_i    = v;
  endtask

  // Advance the model with the currently driven inputs, then clock the DUT.
  task automatic tick();
    int g;
    bit acc;
    ent_t e;
    g   = m_grant(locks_i);
    acc = in_valid_i && (mq.size() < DEPTH);
    e.payload = in_payload_i; e.rd = in_rd_i; e.req = in_reg_req_i;
    e.blk = in_blocking_i;    e.mem = in_mem_op_i;
    if (clear_i) mq.delete();
    else begin
      if (g >= 0 && out_ready_i) mq.delete(g);
      if (acc) mq.push_back(e);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    arst_i = 1'b1;
    #12;
    checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid_o); end
    checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready_o); end
    @(posedge clk_i); #1;
    arst_i = 1'b0;
    mq.delete();
    #2;
    checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready_o); end
  endtask

  task automatic test_basic();
    ent_t a;
    a = mk(16'hA0, 5, '0, 0, 0);
    locks_i = '0; out_ready_i = 1'b0;
    put(a, 1);
    #2;
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL basic_no_bypass got=%0b exp=0", out_valid_o); end
    tick();
    put(a, 0);
    #2;
    checks++; if (out_valid_o !== 1'b1 || out_payload_o !== a.payload || out_rd_o !== 6'd5)
      begin failures++; $display("FAIL basic_launch vld=%0b rd=%0d pay=%0h exp vld=1 rd=5 pay=%0h", out_valid_o, out_rd_o, out_payload_o, a.payload); end
    checks++; if (count_o !== 3'd1) begin failures++; $display("FAIL basic_count1 got=%0d exp=1", count_o); end
    out_ready_i = 1'b1;
    tick();
    #2;
    checks++; if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin failures++; $display("FAIL basic_drain count=%0d vld=%0b exp 0/0", count_o, out_valid_o); end
  endtask

  task automatic test_raw_hazard();
    ent_t a, b;
    a = mk(16'hB1, 5, '0, 0, 0);
    b = mk(16'hB2, 0, bit_of(5), 0, 0);
    locks_i = bit_of(5); out_ready_i = 1'b1;
    put(a, 1); tick();
    put(b, 1); tick();
    put(b, 0);
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL raw_stall cyc=%0d got=%0b exp=0", i, out_valid_o); end
      tick();
    end
    locks_i = '0;
    #2;
    checks++; if (out_valid_o !== 1'b1 || out_payload_o !== a.payload) begin failures++; $display("FAIL raw_first vld=%0b pay=%0h exp=%0h", out_valid_o, out_payload_o, a.payload); end
    tick(); #2;
    checks++; if (out_valid_o !== 1'b1 || out_payload_o !== b.payload || count_o !== 3'd1)
      begin failures++; $display("FAIL raw_second vld=%0b cnt=%0d pay=%0h exp=%0h", out_valid_o, count_o, out_payload_o, b.payload); end
    tick(); #2;
    checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL raw_empty got=%0d exp=0", count_o); end
  endtask

  task automatic test_pass_stalled();
    ent_t a, c;
    a = mk(16'hC1, 0, bit_of(3), 0, 0);
    c = mk(16'hC2, 7, bit_of(1), 0, 0);
    locks_i = bit_of(3); out_ready_i = 1'b0;
    put(a, 1); tick();
    put(c, 1); tick();
    put(c, 0); #2;
    checks++; if (out_valid_o !== 1'b1 || out_payload_o !== c.payload || out_rd_o !== 6'd7)
      begin failures++; $display("FAIL pass_young vld=%0b rd=%0d pay=%0h exp=%0h", out_valid_o, out_rd_o, out_payload_o, c.payload); end
    out_ready_i = 1'b1;
    tick(); #2;
    checks++; if (count_o !== 3'd1 || out_valid_o !== 1'b0) begin failures++; $display("FAIL pass_hold cnt=%0d vld=%0b exp 1/0", count_o, out_valid_o); end
    locks_i = '0; #2;
    checks++; if (out_valid_o !== 1'b1 || out_payload_o !== a.payload) begin failures++; $display("FAIL pass_old pay=%0h exp=%0h", out_payload_o, a.payload); end
    tick();
  endtask

  task automatic test_mem_order();
    ent_t m1, m2;
    m1 = mk(16'hD1, 0, bit_of(2), 0, 1);
    m2 = mk(16'hD2, 9, '0, 0, 1);
    locks_i = bit_of(2); out_ready_i = 1'b1;
    put(m1, 1); tick();
    put(m2, 1); tick();
    put(m2, 0);
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL mem_stall cyc=%0d got=%0b exp=0", i, out_valid_o); end
      tick();
    end
    locks_i = '0; #2;
    checks++; if (out_payload_o !== m1.payload || out_valid_o !== 1'b1) begin failures++; $display("FAIL mem_first pay=%0h exp=%0h", out_payload_o, m1.payload); end
    tick(); #2;
    checks++; if (out_payload_o !== m2.payload || out_valid_o !== 1'b1) begin failures++; $display("FAIL mem_second pay=%0h exp=%0h", out_payload_o, m2.payload); end
    tick();
  endtask

  task automatic test_blocking();
    ent_t x, y, z;
    x = mk(16'hE1, 0, bit_of(4), 0, 0);
    y = mk(16'hE2, 0, '0, 1, 0);
    z = mk(16'hE3, 10, '0, 0, 0);
    locks_i = bit_of(4); out_ready_i = 1'b1;
    put(x, 1); tick();
    put(y, 1); tick();
    put(z, 1); tick();
    put(z, 0); #2;
    checks++; if (out_valid_o !== 1'b0 || count_o !== 3'd3) begin failures++; $display("FAIL blk_stall vld=%0b cnt=%0d exp 0/3", out_valid_o, count_o); end
    tick();
    locks_i = '0; #2;
    checks++; if (out_payload_o !== x.payload) begin failures++; $display("FAIL blk_x pay=%0h exp=%0h", out_payload_o, x.payload); end
    tick(); #2;
    checks++; if (out_payload_o !== y.payload || out_valid_o !== 1'b1) begin failures++; $display("FAIL blk_y pay=%0h exp=%0h", out_payload_o, y.payload); end
    tick(); #2;
    checks++; if (out_payload_o !== z.payload || out_valid_o !== 1'b1) begin failures++; $display("FAIL blk_z pay=%0h exp=%0h", out_payload_o, z.payload); end
    tick();
  endtask

  task automatic test_full_and_clear();
    ent_t f[DEPTH];
    ent_t e;
    locks_i = '0; out_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      f[i] = mk(16'hF0 + i, 0, '0, 0, 0);
      put(f[i], 1); tick();
    end
    e = mk(16'hFE, 0, '0, 0, 0);
    put(e, 1); out_ready_i = 1'b1; #2;
    checks++; if (count_o !== 3'd4 || in_ready_o !== 1'b0) begin failures++; $display("FAIL full cnt=%0d rdy=%0b exp 4/0", count_o, in_ready_o); end
    tick();
    put(e, 0); out_ready_i = 1'b0; #2;
    checks++; if (count_o !== 3'd3 || out_payload_o !== f[1].payload) begin failures++; $display("FAIL full_refuse cnt=%0d pay=%0h exp 3/%0h", count_o, out_payload_o, f[1].payload); end
    put(e, 1); out_ready_i = 1'b1; clear_i = 1'b1; #2;
    checks++; if (in_ready_o !== 1'b1 || out_valid_o !== 1'b1) begin failures++; $display("FAIL clear_hs rdy=%0b vld=%0b exp 1/1", in_ready_o, out_valid_o); end
    tick();
    clear_i = 1'b0; put(e, 0); #2;
    checks++; if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin failures++; $display("FAIL clear cnt=%0d vld=%0b exp 0/0", count_o, out_valid_o); end
  endtask

  task automatic test_random();
    ent_t e;
    int g;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc % 200 == 199) begin
        arst_i = 1'b1; #1;
        mq.delete();
        checks++; if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin failures++; $display("FAIL arst_mid cnt=%0d vld=%0b exp 0/0", count_o, out_valid_o); end
        arst_i = 1'b0;
      end
      locks_i = '0;
      for (int r = 1; r < 8; r++) if ($urandom_range(0, 4) == 0) locks_i[r] = 1'b1;
      e = mk(cyc, $urandom_range(0, 7), NR'($urandom_range(0, 255)) & NR'($urandom_range(0, 255)),
             $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
      put(e, $urandom_range(0, 2) != 0);
      out_ready_i = $urandom_range(0, 3) != 0;
      clear_i     = $urandom_range(0, 60) == 0;
      #2;
      g = m_grant(locks_i);
      checks++; if (count_o !== CW'(mq.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, count_o, mq.size()); end
      checks++; if (in_ready_o !== (mq.size() < DEPTH)) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%0b", cyc, in_ready_o); end
      checks++; if (out_valid_o !== (g >= 0)) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid_o, g >= 0); end
      if (g >= 0) begin
        checks++; if (out_payload_o !== mq[g].payload || out_rd_o !== mq[g].rd)
          begin failures++; $display("FAIL rnd_launch cyc=%0d pay=%0h rd=%0d exp pay=%0h rd=%0d", cyc, out_payload_o, out_rd_o, mq[g].payload, mq[g].rd); end
      end
      tick();
    end
    clear_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw_hazard();
    test_pass_stalled();
    test_mem_order();
    test_blocking();
    test_full_and_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
